apb_master: RTL and testbench

- APB requester (initiator) that turns single read/write commands from a simple valid/ready command port into APB SETUP/ACCESS transfers.
- Drives psel/penable/pwrite/paddr/pwdata and samples prdata/pready/pslverr.
- Returns a one-cycle response pulse carrying read data and error status.
- Sits between on-chip control logic and APB responders such as the APB RAM; includes a wait-state timeout so a hung responder cannot stall the requester.

---
 rtl/apb_pkg.sv | 14 +
 rtl/apb_wait_timer.sv | 31 +++
 rtl/apb_master.sv | 133 +++++++++++++
 tb/tb_apb_master.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB types and defaults for the requester and its helpers.
package apb_pkg;

    localparam int APB_ADDR_W          = 32;
    localparam int APB_DATA_W          = 32;
    localparam int APB_MST_TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_mst_state_e;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS wait states and flags the cycle on which the transfer must be abandoned.
module apb_wait_timer
    import apb_pkg::*;
#(
    parameter int TIMEOUT = APB_MST_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (count_en) begin
            count <= count + CNT_W'(1);
        end
    end

    // Expiry is evaluated before the increment, so the abort lands on the TIMEOUT-th low-pready edge.
    assign expired = (TIMEOUT != 0) && count_en && (count == LAST);

endmodule

// File: rtl/apb_master.sv
// APB requester: one command in, one SETUP/ACCESS transfer out, one registered response pulse back.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = APB_MST_TIMEOUT_DEF
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    apb_mst_state_e    state, state_nxt;
    logic              psel_nxt, penable_nxt, pwrite_nxt;
    logic [ADDR_W-1:0] paddr_nxt;
    logic [DATA_W-1:0] pwdata_nxt, rsp_rdata_nxt;
    logic              rsp_valid_nxt, rsp_err_nxt, rsp_timeout_nxt;
    logic              timer_clear, timer_count, timer_expired;

    assign cmd_ready   = (state == IDLE);
    assign timer_clear = (state == SETUP);
    assign timer_count = (state == ACCESS) && !pready;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk      (pclk),
        .rst      (preset),
        .clear    (timer_clear),
        .count_en (timer_count),
        .expired  (timer_expired)
    );

    always_ff @(posedge pclk) begin
        if (preset) begin
            state       <= IDLE;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= '0;
        end else begin
            state       <= state_nxt;
            psel        <= psel_nxt;
            penable     <= penable_nxt;
            pwrite      <= pwrite_nxt;
            paddr       <= paddr_nxt;
            pwdata      <= pwdata_nxt;
            rsp_valid   <= rsp_valid_nxt;
            rsp_err     <= rsp_err_nxt;
            rsp_timeout <= rsp_timeout_nxt;
            rsp_rdata   <= rsp_rdata_nxt;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the case can infer a latch.
        state_nxt       = state;
        psel_nxt        = psel;
        penable_nxt     = penable;
        pwrite_nxt      = pwrite;
        paddr_nxt       = paddr;
        pwdata_nxt      = pwdata;
        rsp_valid_nxt   = 1'b0;
        rsp_timeout_nxt = 1'b0;
        rsp_err_nxt     = rsp_err;
        rsp_rdata_nxt   = rsp_rdata;

        case (state)
            IDLE: begin
                psel_nxt    = 1'b0;
                penable_nxt = 1'b0;
                if (cmd_valid) begin
                    state_nxt  = SETUP;
                    psel_nxt   = 1'b1;
                    pwrite_nxt = cmd_write;
                    paddr_nxt  = cmd_addr;
                    pwdata_nxt = cmd_write ? cmd_wdata : '0;
                end
            end
            SETUP: begin
                state_nxt   = ACCESS;
                penable_nxt = 1'b1;
            end
            ACCESS: begin
                if (pready) begin
                    state_nxt     = IDLE;
                    psel_nxt      = 1'b0;
                    penable_nxt   = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = pslverr;
                    // Only a clean read forwards prdata; anything else returns zero.
                    rsp_rdata_nxt = (!pwrite && !pslverr) ? prdata : '0;
                end else if (timer_expired) begin
                    state_nxt       = IDLE;
                    psel_nxt        = 1'b0;
                    penable_nxt     = 1'b0;
                    rsp_valid_nxt   = 1'b1;
                    rsp_err_nxt     = 1'b1;
                    rsp_timeout_nxt = 1'b1;
                    rsp_rdata_nxt   = '0;
                end
            end
            default: begin
                state_nxt   = IDLE;
                psel_nxt    = 1'b0;
                penable_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: RAM-like responder with random waits, transaction-level model, per-cycle compare.
module tb_apb_master;

    localparam int DEPTH   = 32;
    localparam int TIMEOUT = 16;

    logic        pclk, preset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic        pready, pslverr;

    apb_master #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .pclk        (pclk),
        .preset      (preset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr)
    );

    // w = number of ACCESS wait states the responder inserts; -1 means it never answers.
    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          w;
        int          a;
        logic        err;
        logic        to;
        logic [31:0] rdata;
    } txn_t;

    int          n_cmp = 0;
    int          n_err = 0;
    int          edge_cnt = 0;
    logic        rst_q = 1'b1;
    logic        started = 1'b0;
    int          cur_w = 0;
    int          last_accept = 0;
    int          last_rsp_edge = 0;
    txn_t        pend[$];
    txn_t        act;
    logic        act_valid = 1'b0;
    logic        last_err = 1'b0;
    logic [31:0] last_rdata = '0;
    logic [31:0] ram[DEPTH];
    logic [31:0] ref_mem[DEPTH];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s @edge %0d: got %h expected %h", name, edge_cnt, actual, expected);
        end
    endtask

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    initial forever begin
        @(posedge pclk);
        edge_cnt++;
        rst_q = preset;
    end

    // Responder: random pready/pslverr/prdata outside ACCESS to prove they are ignored.
    initial begin
        int w_left = 0;
        forever begin
            @(negedge pclk);
            pready  = 1'($urandom_range(0, 1));
            pslverr = 1'($urandom_range(0, 1));
            prdata  = $urandom;
            if (psel && !penable) begin
                w_left = cur_w;
            end else if (psel && penable) begin
                if (w_left == 0) begin
                    pready  = 1'b1;
                    pslverr = (paddr >= 32'(DEPTH));
                    if (!pslverr) begin
                        if (pwrite) ram[paddr[4:0]] = pwdata;
                        else        prdata = ram[paddr[4:0]];
                    end
                end else begin
                    pready = 1'b0;
                    if (w_left > 0) w_left--;
                end
            end
        end
    end

    // Compare process: expected bus/response activity is derived from accept edge and wait count.
    initial forever begin
        int k, d, r;
        @(negedge pclk);
        if (!started) continue;
        k = edge_cnt;
        if (rsp_valid) last_rsp_edge = k;
        if (rst_q) begin
            check("rst_psel", 32'(psel), 0);
            check("rst_penable", 32'(penable), 0);
            check("rst_pwrite", 32'(pwrite), 0);
            check("rst_paddr", paddr, 0);
            check("rst_pwdata", pwdata, 0);
            check("rst_rsp_valid", 32'(rsp_valid), 0);
            check("rst_rsp_err", 32'(rsp_err), 0);
            check("rst_rsp_timeout", 32'(rsp_timeout), 0);
            check("rst_rsp_rdata", rsp_rdata, 0);
            check("rst_cmd_ready", 32'(cmd_ready), 1);
            act_valid  = 1'b0;
            pend.delete();
            last_err   = 1'b0;
            last_rdata = '0;
            continue;
        end
        if (!act_valid && pend.size() > 0 && pend[0].a <= k) begin
            act       = pend.pop_front();
            act_valid = 1'b1;
        end
        if (act_valid) begin
            d = k - act.a;
            r = (act.w < 0) ? TIMEOUT + 1 : act.w + 2;
            if (d < r) begin
                check("xfer_psel", 32'(psel), 1);
                check("xfer_penable", 32'(penable), (d >= 1) ? 1 : 0);
                check("xfer_pwrite", 32'(pwrite), 32'(act.wr));
                check("xfer_paddr", paddr, act.addr);
                check("xfer_pwdata", pwdata, act.wr ? act.wdata : 32'h0);
                check("xfer_rsp_valid", 32'(rsp_valid), 0);
                check("xfer_rsp_err_hold", 32'(rsp_err), 32'(last_err));
                check("xfer_rsp_rdata_hold", rsp_rdata, last_rdata);
                check("xfer_cmd_ready", 32'(cmd_ready), 0);
            end else begin
                check("rsp_psel", 32'(psel), 0);
                check("rsp_penable", 32'(penable), 0);
                check("rsp_valid", 32'(rsp_valid), 1);
                check("rsp_err", 32'(rsp_err), 32'(act.err));
                check("rsp_timeout", 32'(rsp_timeout), 32'(act.to));
                check("rsp_rdata", rsp_rdata, act.rdata);
                check("rsp_cmd_ready", 32'(cmd_ready), 1);
                last_err   = act.err;
                last_rdata = act.rdata;
                act_valid  = 1'b0;
            end
        end else begin
            check("idle_psel", 32'(psel), 0);
            check("idle_penable", 32'(penable), 0);
            check("idle_rsp_valid", 32'(rsp_valid), 0);
            check("idle_rsp_timeout", 32'(rsp_timeout), 0);
            check("idle_rsp_err_hold", 32'(rsp_err), 32'(last_err));
            check("idle_rsp_rdata_hold", rsp_rdata, last_rdata);
            check("idle_cmd_ready", 32'(cmd_ready), 1);
        end
    end

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] wdata, input int w);
        txn_t t;
        int   guard = 0;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_valid = 1'b1;
        while (!cmd_ready && guard < 100) begin
            @(negedge pclk);
            guard++;
        end
        if (!cmd_ready) begin
            check("cmd_accept_timeout", 32'(cmd_ready), 1);
            cmd_valid = 1'b0;
            return;
        end
        t.wr = wr; t.addr = addr; t.wdata = wdata; t.w = w;
        t.a  = edge_cnt + 1;
        if (w < 0) begin
            t.err = 1'b1; t.to = 1'b1; t.rdata = '0;
        end else if (addr >= 32'(DEPTH)) begin
            t.err = 1'b1; t.to = 1'b0; t.rdata = '0;
        end else if (wr) begin
            ref_mem[addr[4:0]] = wdata;
            t.err = 1'b0; t.to = 1'b0; t.rdata = '0;
        end else begin
            t.err = 1'b0; t.to = 1'b0; t.rdata = ref_mem[addr[4:0]];
        end
        pend.push_back(t);
        cur_w       = w;
        last_accept = t.a;
        @(negedge pclk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int guard = 0;
        while ((act_valid || pend.size() != 0) && guard < 200) begin
            @(negedge pclk);
            guard++;
        end
        if (act_valid || pend.size() != 0) check("rsp_wait_timeout", 32'(guard), 0);
        @(negedge pclk);
    endtask

    initial begin
        logic [31:0] v;
        preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0;
        cmd_addr = '0; cmd_wdata = '0;
        pready = 1'b0; pslverr = 1'b0; prdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            v = $urandom;
            ram[i] = v;
            ref_mem[i] = v;
        end
        repeat (2) @(negedge pclk);
        started = 1'b1;
        @(negedge pclk);
        preset = 1'b0;

        // Write then read back through the responder RAM.
        send(1'b1, 32'd5, 32'hDEADBEEF, 1);
        send(1'b0, 32'd5, 32'h0, 2);
        wait_done();
        check("pin_readback_data", rsp_rdata, 32'hDEADBEEF);
        check("pin_readback_err", 32'(rsp_err), 0);

        // Out-of-range write is rejected by the responder.
        send(1'b1, 32'd40, 32'h12345678, 0);
        wait_done();
        check("pin_oor_err", 32'(rsp_err), 1);
        check("pin_oor_rdata", rsp_rdata, 0);

        // Zero-wait read: response visible right after accept edge + 2.
        send(1'b0, 32'd5, 32'h0, 0);
        wait_done();
        check("pin_zero_wait_latency", 32'(last_rsp_edge - last_accept), 2);
        check("pin_zero_wait_data", rsp_rdata, 32'hDEADBEEF);

        // Hung responder: abort after 16 low-pready ACCESS edges.
        send(1'b0, 32'd3, 32'h0, -1);
        wait_done();
        check("pin_timeout_latency", 32'(last_rsp_edge - last_accept), 17);
        check("pin_timeout_err", 32'(rsp_err), 1);

        // Back-to-back writes with cmd_valid held, then readback.
        for (int i = 0; i < 4; i++) send(1'b1, 32'(i), 32'hA0A0_0000 | 32'(i), int'($urandom_range(0, 2)));
        for (int i = 0; i < 4; i++) send(1'b0, 32'(i), 32'h0, int'($urandom_range(0, 2)));
        wait_done();
        check("pin_b2b_last_read", rsp_rdata, 32'hA0A0_0003);

        // Reset while in ACCESS: bus idles, no response, next command works.
        send(1'b0, 32'd1, 32'h0, 8);
        @(negedge pclk);
        preset = 1'b1;
        @(negedge pclk);
        preset = 1'b0;
        repeat (12) @(negedge pclk);
        check("pin_no_rsp_after_reset", 32'(last_rsp_edge < last_accept), 1);
        send(1'b0, 32'd2, 32'h0, 1);
        wait_done();
        check("pin_post_reset_read", rsp_rdata, 32'hA0A0_0002);

        // Randomised traffic.
        for (int i = 0; i < 300; i++) begin
            logic [31:0] addr;
            int          w;
            repeat ($urandom_range(0, 2)) @(negedge pclk);
            addr = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, DEPTH + 7));
            w    = ($urandom_range(0, 19) == 0) ? -1 : int'($urandom_range(0, 3));
            send(1'($urandom_range(0, 1)), addr, $urandom, w);
        end
        wait_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
